// File: rtl/decoder_3b4b.sv
// Receive-side 3B/4B decoder (fghj -> HGF) with running-disparity tracking and a link sync FSM.
// Optional saturating error counter enabled by defining DECODER_3B4B_ERR_CNT_EN.
module decoder_3b4b #(
   parameter int unsigned SYNC_CNT  = 8,
   parameter int unsigned LOSS_CNT  = 4,
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [3:0]           i_code,
   input  logic                 i_enb,
   input  logic                 i_rd_load,
   input  logic                 i_rd_in,
   input  logic                 i_err_clr,
   output logic [2:0]           o_data_out,
   output logic                 o_rd_out,
   output logic                 o_valid,
   output logic                 o_code_err,
   output logic                 o_disp_err,
   output logic                 o_sync,
   output logic [ERR_CNT_W-1:0] o_err_cnt
);

   localparam logic [1:0] ST_LOS  = 2'd0;
   localparam logic [1:0] ST_ACQ  = 2'd1;
   localparam logic [1:0] ST_SYNC = 2'd2;

   localparam logic [7:0] SYNC_LIM = 8'(SYNC_CNT);
   localparam logic [7:0] LOSS_LIM = 8'(LOSS_CNT);

   logic       rd_q;
   logic       rd_cur;
   logic       rd_next;
   logic [2:0] dec_x;
   logic       need_neg;
   logic       need_pos;
   logic       code_err;
   logic       disp_err;
   logic       bad;
   logic [2:0] weight;

   logic [1:0] st_q, st_d;
   logic [7:0] good_q, good_d;
   logic [7:0] badc_q, badc_d;

   // A same-cycle RD preset overrides the tracked RD for this code group's check.
   assign rd_cur = i_rd_load ? i_rd_in : rd_q;

   always_comb begin
      dec_x    = '0;
      need_neg = 1'b0;
      need_pos = 1'b0;
      code_err = 1'b0;
      case (i_code)
         4'b1011: begin dec_x = 3'd0; need_neg = 1'b1; end
         4'b0100: begin dec_x = 3'd0; need_pos = 1'b1; end
         4'b1001: dec_x = 3'd1;
         4'b0101: dec_x = 3'd2;
         4'b1100: begin dec_x = 3'd3; need_neg = 1'b1; end
         4'b0011: begin dec_x = 3'd3; need_pos = 1'b1; end
         4'b1101: begin dec_x = 3'd4; need_neg = 1'b1; end
         4'b0010: begin dec_x = 3'd4; need_pos = 1'b1; end
         4'b1010: dec_x = 3'd5;
         4'b0110: dec_x = 3'd6;
         4'b1110: begin dec_x = 3'd7; need_neg = 1'b1; end
         4'b0001: begin dec_x = 3'd7; need_pos = 1'b1; end
         4'b0111: begin dec_x = 3'd7; need_neg = 1'b1; end
         4'b1000: begin dec_x = 3'd7; need_pos = 1'b1; end
         default: code_err = 1'b1;
      endcase
   end

   assign disp_err = (need_neg & rd_cur) | (need_pos & ~rd_cur);
   assign bad      = code_err | disp_err;
   assign weight   = {2'b0, i_code[3]} + {2'b0, i_code[2]} + {2'b0, i_code[1]} + {2'b0, i_code[0]};

   always_comb begin
      if (weight >= 3'd3)      rd_next = 1'b1;
      else if (weight <= 3'd1) rd_next = 1'b0;
      else                     rd_next = rd_cur;
   end

   always_comb begin
      st_d   = st_q;
      good_d = good_q;
      badc_d = badc_q;
      case (st_q)
         ST_LOS: begin
            if (!bad) begin
               if (SYNC_LIM == 8'd1) begin
                  st_d = ST_SYNC;
               end else begin
                  st_d   = ST_ACQ;
                  good_d = 8'd1;
               end
               badc_d = '0;
            end
         end
         ST_ACQ: begin
            if (bad) begin
               st_d   = ST_LOS;
               good_d = '0;
            end else begin
               good_d = good_q + 8'd1;
               if (good_d == SYNC_LIM) begin
                  st_d   = ST_SYNC;
                  badc_d = '0;
               end
            end
         end
         ST_SYNC: begin
            if (bad) begin
               badc_d = badc_q + 8'd1;
               if (badc_d == LOSS_LIM) begin
                  st_d   = ST_LOS;
                  badc_d = '0;
                  good_d = '0;
               end
            end else begin
               badc_d = '0;
            end
         end
         default: begin
            st_d   = ST_LOS;
            good_d = '0;
            badc_d = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_q       <= 1'b0;
         st_q       <= ST_LOS;
         good_q     <= '0;
         badc_q     <= '0;
         o_data_out <= '0;
         o_rd_out   <= 1'b0;
         o_valid    <= 1'b0;
         o_code_err <= 1'b0;
         o_disp_err <= 1'b0;
         o_sync     <= 1'b0;
      end else begin
         o_valid <= i_enb;
         if (i_enb) begin
            rd_q       <= rd_next;
            st_q       <= st_d;
            good_q     <= good_d;
            badc_q     <= badc_d;
            o_data_out <= dec_x;
            o_rd_out   <= rd_next;
            o_code_err <= code_err;
            o_disp_err <= disp_err;
            o_sync     <= (st_d == ST_SYNC);
         end else if (i_rd_load) begin
            rd_q <= i_rd_in;
         end
      end
   end

`ifdef DECODER_3B4B_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] err_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         err_q <= '0;
      end else if (i_err_clr) begin
         err_q <= '0;
      end else if (i_enb && bad && (err_q != '1)) begin
         err_q <= err_q + 1'b1;
      end
   end

   assign o_err_cnt = err_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = i_err_clr;
   assign o_err_cnt      = '0;
`endif

endmodule

// File: tb/tb_decoder_3b4b.sv
// Scoreboard bench for decoder_3b4b: reference decoder/RD/sync/error model feeds an expected-result queue.
// A second instance with a 2-bit error counter covers saturation.
module tb_decoder_3b4b;

   localparam int unsigned SYNC_N = 8;
   localparam int unsigned LOSS_N = 4;
`ifdef DECODER_3B4B_ERR_CNT_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef struct packed {
      logic [2:0] d;
      logic       rd;
      logic       ce;
      logic       de;
      logic       sy;
      logic [7:0] ec;
   } exp_t;

   logic       clk = 1'b0;
   logic       i_rst_n;
   logic [3:0] i_code;
   logic       i_enb, i_rd_load, i_rd_in, i_err_clr;
   logic [2:0] o_data_out;
   logic       o_rd_out, o_valid, o_code_err, o_disp_err, o_sync;
   logic [7:0] o_err_cnt;
   logic [2:0] unused_s_data;
   logic       unused_s_rd, unused_s_valid, unused_s_ce, unused_s_de, unused_s_sync;
   logic [1:0] s_err_cnt;

   always #5 clk = ~clk;

   decoder_3b4b #(.SYNC_CNT(SYNC_N), .LOSS_CNT(LOSS_N), .ERR_CNT_W(8)) dut (
      .i_clk(clk), .i_rst_n(i_rst_n), .i_code(i_code), .i_enb(i_enb),
      .i_rd_load(i_rd_load), .i_rd_in(i_rd_in), .i_err_clr(i_err_clr),
      .o_data_out(o_data_out), .o_rd_out(o_rd_out), .o_valid(o_valid),
      .o_code_err(o_code_err), .o_disp_err(o_disp_err), .o_sync(o_sync),
      .o_err_cnt(o_err_cnt)
   );

   decoder_3b4b #(.SYNC_CNT(SYNC_N), .LOSS_CNT(LOSS_N), .ERR_CNT_W(2)) dut_sat (
      .i_clk(clk), .i_rst_n(i_rst_n), .i_code(i_code), .i_enb(i_enb),
      .i_rd_load(i_rd_load), .i_rd_in(i_rd_in), .i_err_clr(i_err_clr),
      .o_data_out(unused_s_data), .o_rd_out(unused_s_rd), .o_valid(unused_s_valid),
      .o_code_err(unused_s_ce), .o_disp_err(unused_s_de), .o_sync(unused_s_sync),
      .o_err_cnt(s_err_cnt)
   );

   int   n_total = 0;
   int   n_pass  = 0;
   exp_t sb[$];

   logic m_rd;
   int   m_st, m_good, m_bad, m_ec, m_ec2;

   // {legal, x[2:0], RD- only, RD+ only}
   function automatic logic [5:0] ref_dec(input logic [3:0] c);
      case (c)
         4'b1011: return {1'b1, 3'd0, 2'b10};
         4'b0100: return {1'b1, 3'd0, 2'b01};
         4'b1001: return {1'b1, 3'd1, 2'b00};
         4'b0101: return {1'b1, 3'd2, 2'b00};
         4'b1100: return {1'b1, 3'd3, 2'b10};
         4'b0011: return {1'b1, 3'd3, 2'b01};
         4'b1101: return {1'b1, 3'd4, 2'b10};
         4'b0010: return {1'b1, 3'd4, 2'b01};
         4'b1010: return {1'b1, 3'd5, 2'b00};
         4'b0110: return {1'b1, 3'd6, 2'b00};
         4'b1110: return {1'b1, 3'd7, 2'b10};
         4'b0001: return {1'b1, 3'd7, 2'b01};
         4'b0111: return {1'b1, 3'd7, 2'b10};
         4'b1000: return {1'b1, 3'd7, 2'b01};
         default: return 6'b0;
      endcase
   endfunction

   // Transmit-side 3B/4B encoder view: picks the code for the current RD.
   function automatic logic [3:0] enc(input int x, input logic rd, input bit alt);
      logic [3:0] neg_t [8];
      logic [3:0] pos_t [8];
      neg_t = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
      pos_t = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
      if (x == 7 && alt) return rd ? 4'b1000 : 4'b0111;
      return rd ? pos_t[x] : neg_t[x];
   endfunction

   task automatic model_reset();
      m_rd = 1'b0; m_st = 0; m_good = 0; m_bad = 0; m_ec = 0; m_ec2 = 0;
      sb.delete();
   endtask

   task automatic drive(input logic enb, input logic [3:0] code, input logic load,
                        input logic rdin, input logic clr);
      logic [5:0] r;
      logic rdc, ce, de, bad;
      int w;
      @(negedge clk);
      i_enb = enb; i_code = code; i_rd_load = load; i_rd_in = rdin; i_err_clr = clr;
      rdc = load ? rdin : m_rd;
      r = ref_dec(code);
      ce = !r[5];
      de = (r[1] && rdc) || (r[0] && !rdc);
      bad = 1'b0;
      if (enb) begin
         bad = ce | de;
         w = $countones(code);
         if (w >= 3) m_rd = 1'b1;
         else if (w <= 1) m_rd = 1'b0;
         else m_rd = rdc;
         if (!bad) begin
            if (m_st == 0) begin m_st = 1; m_good = 1; m_bad = 0; end
            else if (m_st == 1) begin m_good++; if (m_good == SYNC_N) begin m_st = 2; m_bad = 0; end end
            else m_bad = 0;
         end else begin
            if (m_st == 1) begin m_st = 0; m_good = 0; end
            else if (m_st == 2) begin m_bad++; if (m_bad == LOSS_N) begin m_st = 0; m_bad = 0; m_good = 0; end end
         end
      end else if (load) begin
         m_rd = rdin;
      end
      if (ERR_EN) begin
         if (clr) begin m_ec = 0; m_ec2 = 0; end
         else if (enb && bad) begin
            if (m_ec < 255) m_ec++;
            if (m_ec2 < 3) m_ec2++;
         end
      end
      if (enb) sb.push_back({r[4:2], m_rd, ce, de, (m_st == 2), 8'(m_ec)});
      @(posedge clk); #1;
      i_enb = 1'b0; i_rd_load = 1'b0; i_err_clr = 1'b0;
   endtask

   task automatic do_reset();
      exp_t a;
      @(negedge clk);
      i_rst_n = 1'b0; i_enb = 1'b0; i_code = '0; i_rd_load = 1'b0; i_rd_in = 1'b0; i_err_clr = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      a = {o_data_out, o_rd_out, o_code_err, o_disp_err, o_sync, o_err_cnt};
      n_total++;
      if (a !== '0 || o_valid !== 1'b0 || s_err_cnt !== 2'b0)
         $display("FAIL reset_state: got %h valid=%b sat=%h, expected all zero", a, o_valid, s_err_cnt);
      else n_pass++;
      @(negedge clk);
      i_rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
   endtask

   task automatic test_basic();
      exp_t e, a;
      drive(1'b1, 4'b1011, 1'b0, 1'b0, 1'b0);
      e = sb.pop_front();
      a = {o_data_out, o_rd_out, o_code_err, o_disp_err, o_sync, o_err_cnt};
      n_total++;
      if (o_valid !== 1'b1 || a !== e || e.d !== 3'd0 || e.rd !== 1'b1)
         $display("FAIL basic_1011: got %h valid=%b, expected %h", a, o_valid, e);
      else n_pass++;
      drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
      n_total++;
      if (o_valid !== 1'b0 || o_data_out !== 3'd0 || o_rd_out !== 1'b1)
         $display("FAIL idle_hold: got valid=%b d=%h rd=%b, expected 0/0/1", o_valid, o_data_out, o_rd_out);
      else n_pass++;
   endtask

   task automatic test_loopback();
      exp_t e, a;
      logic enc_rd;
      logic [3:0] c;
      enc_rd = m_rd;
      for (int p = 0; p < 4; p++) begin
         for (int x = 0; x < 8; x++) begin
            c = enc(x, enc_rd, (p >= 2));
            if ($countones(c) != 2) enc_rd = ~enc_rd;
            drive(1'b1, c, 1'b0, 1'b0, 1'b0);
            e = sb.pop_front();
            a = {o_data_out, o_rd_out, o_code_err, o_disp_err, o_sync, o_err_cnt};
            n_total++;
            if (o_valid !== 1'b1 || a !== e || o_data_out !== 3'(x) || o_rd_out !== enc_rd ||
                o_code_err !== 1'b0 || o_disp_err !== 1'b0)
               $display("FAIL loopback x=%0d code=%b: got %h valid=%b, expected %h enc_rd=%b",
                        x, c, a, o_valid, e, enc_rd);
            else n_pass++;
         end
      end
   endtask

   task automatic test_disparity();
      exp_t e, a;
      drive(1'b1, 4'b1011, 1'b1, 1'b1, 1'b0);
      e = sb.pop_front();
      a = {o_data_out, o_rd_out, o_code_err, o_disp_err, o_sync, o_err_cnt};
      n_total++;
      if (a !== e || e.de !== 1'b1 || e.d !== 3'd0 || e.rd !== 1'b1)
         $display("FAIL disp_err_rdplus: got %h, expected %h", a, e);
      else n_pass++;
      drive(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
      e = sb.pop_front();
      a = {o_data_out, o_rd_out, o_code_err, o_disp_err, o_sync, o_err_cnt};
      n_total++;
      if (a !== e || e.ce !== 1'b1 || e.de !== 1'b0)
         $display("FAIL code_err_1111: got %h, expected %h", a, e);
      else n_pass++;
      // RD preset alone, then a code legal only at RD-.
      drive(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
      n_total++;
      if (o_valid !== 1'b0)
         $display("FAIL rd_load_no_valid: got valid=%b, expected 0", o_valid);
      else n_pass++;
      drive(1'b1, 4'b1101, 1'b0, 1'b0, 1'b0);
      e = sb.pop_front();
      a = {o_data_out, o_rd_out, o_code_err, o_disp_err, o_sync, o_err_cnt};
      n_total++;
      if (a !== e || e.de !== 1'b0 || e.d !== 3'd4)
         $display("FAIL rd_load_alone: got %h, expected %h", a, e);
      else n_pass++;
   endtask

   task automatic test_sync();
      exp_t e, a;
      logic enc_rd;
      logic [3:0] c;
      do_reset();
      enc_rd = 1'b0;
      for (int i = 0; i < 8; i++) begin
         c = enc(i, enc_rd, 1'b0);
         if ($countones(c) != 2) enc_rd = ~enc_rd;
         drive(1'b1, c, 1'b0, 1'b0, 1'b0);
         e = sb.pop_front();
         a = {o_data_out, o_rd_out, o_code_err, o_disp_err, o_sync, o_err_cnt};
         n_total++;
         if (a !== e || o_sync !== (i == 7))
            $display("FAIL sync_acq i=%0d: got %h, expected %h", i, a, e);
         else n_pass++;
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
         e = sb.pop_front();
         a = {o_data_out, o_rd_out, o_code_err, o_disp_err, o_sync, o_err_cnt};
         n_total++;
         if (a !== e || o_sync !== (i != 3))
            $display("FAIL sync_loss i=%0d: got %h, expected %h", i, a, e);
         else n_pass++;
      end
      n_total++;
      if (o_err_cnt !== (ERR_EN ? 8'd4 : 8'd0))
         $display("FAIL err_cnt_after_loss: got %0d, expected %0d", o_err_cnt, ERR_EN ? 4 : 0);
      else n_pass++;
   endtask

   task automatic test_err_sat();
      exp_t e, a;
      drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
         e = sb.pop_front();
         a = {o_data_out, o_rd_out, o_code_err, o_disp_err, o_sync, o_err_cnt};
         n_total++;
         if (a !== e || s_err_cnt !== 2'(m_ec2))
            $display("FAIL err_sat i=%0d: got %h sat=%0d, expected %h sat=%0d", i, a, s_err_cnt, e, m_ec2);
         else n_pass++;
      end
      n_total++;
      if (s_err_cnt !== (ERR_EN ? 2'd3 : 2'd0))
         $display("FAIL err_saturated: got %0d, expected %0d", s_err_cnt, ERR_EN ? 3 : 0);
      else n_pass++;
      drive(1'b1, 4'b1111, 1'b0, 1'b0, 1'b1);
      e = sb.pop_front();
      a = {o_data_out, o_rd_out, o_code_err, o_disp_err, o_sync, o_err_cnt};
      n_total++;
      if (a !== e || s_err_cnt !== 2'd0 || o_err_cnt !== 8'd0)
         $display("FAIL err_clr_wins: got %h sat=%0d, expected %h sat=0", a, s_err_cnt, e);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      exp_t e, a;
      drive(1'b1, 4'b1011, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
      sb.delete();
      @(negedge clk);
      #2 i_rst_n = 1'b0;
      #1;
      model_reset();
      a = {o_data_out, o_rd_out, o_code_err, o_disp_err, o_sync, o_err_cnt};
      n_total++;
      if (a !== '0 || o_valid !== 1'b0 || s_err_cnt !== 2'd0)
         $display("FAIL async_reset: got %h valid=%b, expected all zero", a, o_valid);
      else n_pass++;
      @(negedge clk);
      i_rst_n = 1'b1;
      drive(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0);
      e = sb.pop_front();
      a = {o_data_out, o_rd_out, o_code_err, o_disp_err, o_sync, o_err_cnt};
      n_total++;
      if (a !== e || e.de !== 1'b1 || o_valid !== 1'b1)
         $display("FAIL post_reset_rdminus: got %h valid=%b, expected %h", a, o_valid, e);
      else n_pass++;
   endtask

   initial begin
      i_rst_n = 1'b0; i_enb = 1'b0; i_code = '0; i_rd_load = 1'b0; i_rd_in = 1'b0; i_err_clr = 1'b0;
      model_reset();
      test_reset();
      test_basic();
      test_loopback();
      test_disparity();
      test_sync();
      test_err_sat();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
